// File: rtl/or_reduce_stream.sv
// or_reduce_stream: folds each framed stream of WIDTH-bit words into one word
// using a per-frame bitwise operation (OR, AND, XOR, NOR), then presents the
// result together with a saturating word count, an any-bit flag and an
// overflow flag until the consumer accepts it.
module or_reduce_stream #(
  parameter int WIDTH     = 16,
  parameter int MAX_WORDS = 255,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_any,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_acc_next;
  logic [1:0]       w_op_next;
  logic [CW-1:0]    w_count_next;
  logic             w_ovf_next;
  logic [WIDTH-1:0] w_fold;
  logic [WIDTH-1:0] w_out_data;
  logic             w_hold;

  // NOR accumulates with OR; the inversion is applied only at the output.
  function automatic logic [WIDTH-1:0] fold_word(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    case (op)
      OP_AND:  fold_word = a & b;
      OP_XOR:  fold_word = a ^ b;
      default: fold_word = a | b;
    endcase
  endfunction

  assign w_fold = fold_word(r_op, r_acc, in_data);
  assign w_hold = (r_state == S_HOLD);

  // Next-state and datapath update; in_ready is high in IDLE/ACCUM, so
  // in_valid alone means a transfer there.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_op_next    = r_op;
    w_count_next = r_count;
    w_ovf_next   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_acc_next   = in_data;
          w_op_next    = in_op;
          w_count_next = CW'(1);
          w_ovf_next   = 1'b0;
          w_state_next = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          w_acc_next = w_fold;
          if (r_count < MAX_CNT) begin
            w_count_next = r_count + CW'(1);
          end else begin
            w_ovf_next = 1'b1;
          end
          if (in_last) begin
            w_state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and frame registers; reset discards any partial frame or result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_op    <= OP_OR;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_op    <= w_op_next;
      r_count <= w_count_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // Outputs are decoded from registered state only, so they stay stable
  // throughout backpressure and read as zero outside HOLD.
  always_comb begin
    w_out_data   = '0;
    out_count    = '0;
    out_overflow = 1'b0;
    if (w_hold) begin
      w_out_data   = (r_op == OP_NOR) ? ~r_acc : r_acc;
      out_count    = r_count;
      out_overflow = r_ovf;
    end
  end

  assign in_ready  = ~w_hold;
  assign out_valid = w_hold;
  assign out_data  = w_out_data;
  assign out_any   = |w_out_data;

endmodule

// File: tb/tb_or_reduce_stream.sv
// Bench for or_reduce_stream with a small MAX_WORDS so overflow is reachable.
// Directed frames followed by random frames, checked against a reference
// model that folds a queue of words with plain bitwise operators.
module tb_or_reduce_stream;

  localparam int WIDTH     = 16;
  localparam int MAX_WORDS = 3;
  localparam int CW        = $clog2(MAX_WORDS + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic [1:0]       in_op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_any;
  logic [CW-1:0]    out_count;
  logic             out_overflow;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] frame_q[$];
  logic [WIDTH-1:0] exp_data;
  logic             exp_any;
  int               exp_count;
  logic             exp_ovf;

  always #5 clk = ~clk;

  or_reduce_stream #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_any      (out_any),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: fold the whole frame, NOR = inverted OR of all words.
  task automatic model(input logic [1:0] op);
    logic [WIDTH-1:0] a;
    a = frame_q[0];
    for (int i = 1; i < frame_q.size(); i++) begin
      case (op)
        2'b01:   a = a & frame_q[i];
        2'b10:   a = a ^ frame_q[i];
        default: a = a | frame_q[i];
      endcase
    end
    exp_data  = (op == 2'b11) ? ~a : a;
    exp_any   = (exp_data != '0);
    exp_count = (frame_q.size() > MAX_WORDS) ? MAX_WORDS : frame_q.size();
    exp_ovf   = (frame_q.size() > MAX_WORDS);
  endtask

  task automatic chk_result(input string tag);
    chk({tag, ".data"}, 32'(out_data), 32'(exp_data));
    chk({tag, ".any"}, 32'(out_any), 32'(exp_any));
    chk({tag, ".count"}, 32'(out_count), 32'(exp_count));
    chk({tag, ".ovf"}, 32'(out_overflow), 32'(exp_ovf));
  endtask

  // Send frame_q with first-word op; later words carry scrambled ops.
  // Then hold the result for hold_cyc cycles with a junk word offered.
  task automatic run_frame(input string tag, input logic [1:0] op,
                           input int hold_cyc, input bit gaps);
    model(op);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 1)); g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 16'($urandom);
        end
      end
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = frame_q[i];
      in_last  = (i == frame_q.size() - 1);
      in_op    = (i == 0) ? op : 2'($urandom);
      @(posedge clk);
      #1;
      if (i != frame_q.size() - 1) chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
    end
    chk({tag, ".latency"}, 32'(out_valid), 32'd1);
    for (int h = 0; h < hold_cyc; h++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'($urandom);
      in_last   = 1'b1;
      in_op     = 2'($urandom);
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      chk_result({tag, ".hold"});
    end
    @(negedge clk);
    out_ready = 1'b1;
    chk_result(tag);
    @(posedge clk);
    #1;
    chk({tag, ".done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".done_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    $display("frame %s op=%0d words=%0d data=%h count=%0d ovf=%0d",
             tag, op, frame_q.size(), exp_data, exp_count, exp_ovf);
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    frame_q = '{16'hAAAA, 16'h5555};
    run_frame("or", 2'b00, 0, 1'b0);
    frame_q = '{16'hCCCC, 16'hAAAA};
    run_frame("and", 2'b01, 0, 1'b0);
    frame_q = '{16'hCCCC, 16'hAAAA};
    run_frame("xor", 2'b10, 0, 1'b0);
    frame_q = '{16'h0000};
    run_frame("nor0", 2'b11, 0, 1'b0);
    frame_q = '{16'hFFFF};
    run_frame("nor1", 2'b11, 0, 1'b0);
    frame_q = '{16'hF0F0, 16'hFFFF, 16'h3C3C};
    run_frame("bp_and", 2'b01, 5, 1'b0);
    frame_q = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    run_frame("ovf", 2'b00, 0, 1'b0);
    frame_q = '{16'h0100, 16'h0010};
    run_frame("post_ovf", 2'b00, 0, 1'b0);

    // Reset mid-frame after two words: the partial frame is discarded.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      in_last  = 1'b0;
      in_op    = 2'b00;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    $display("reset asserted mid-frame");
    frame_q = '{16'h0001};
    run_frame("after_rst", 2'b00, 0, 1'b0);

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      frame_q.delete();
      for (int w = 0; w < int'($urandom_range(1, 6)); w++) frame_q.push_back(16'($urandom));
      run_frame($sformatf("rnd%0d", f), 2'($urandom), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
